fifo_buffer_stage: RTL and testbench

- Elastic FIFO stage placed directly downstream of each sbox1x2 output port.
- Absorbs the out1/out2 write stream while the consuming actor is busy.
- Upstream side uses the same data/write/full_n handshake the sbox drives.
- Downstream side presents first-word-fall-through data with empty_n/read handshake to the next actor.

---
 rtl/fifo_buffer_stage_if.sv | 33 +++
 rtl/fifo_buffer_stage.sv | 54 +++++
 tb/tb_fifo_buffer_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fifo_buffer_stage_if.sv
// Handshake bundle for fifo_buffer_stage: sbox-style write side, FWFT read side.
// The occupancy/overflow signals exist only when FIFO_COUNT_EN is defined.
interface fifo_buffer_stage_if #(
   parameter int SIZE   = 32,
   parameter int ADDR_W = 2
);
   logic [SIZE-1:0] in1_data;
   logic            in1_write;
   logic            in1_full_n;
   logic [SIZE-1:0] out1_data;
   logic            out1_empty_n;
   logic            out1_read;
`ifdef FIFO_COUNT_EN
   logic [ADDR_W:0] out1_count;
   logic            out1_ovf;
`endif

   modport master (
      output in1_data, in1_write, out1_read,
      input  in1_full_n, out1_data, out1_empty_n
`ifdef FIFO_COUNT_EN
      , input out1_count, out1_ovf
`endif
   );

   modport slave (
      input  in1_data, in1_write, out1_read,
      output in1_full_n, out1_data, out1_empty_n
`ifdef FIFO_COUNT_EN
      , output out1_count, out1_ovf
`endif
   );
endinterface

// File: rtl/fifo_buffer_stage.sv
// Elastic first-word-fall-through FIFO stage behind an sbox output port.
// Define FIFO_COUNT_EN to expose occupancy and a sticky overflow flag.
module fifo_buffer_stage #(
   parameter int SIZE   = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input logic clock,
   input logic reset,
   fifo_buffer_stage_if.slave bus
);
   logic [SIZE-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   logic              wr_en, rd_en;

   // Flags come straight from the registered count, never from the inputs.
   assign bus.in1_full_n   = (count != (ADDR_W+1)'(DEPTH));
   assign bus.out1_empty_n = (count != '0);
   assign bus.out1_data    = mem[rd_ptr];

   assign wr_en = bus.in1_write && bus.in1_full_n;
   assign rd_en = bus.out1_read && bus.out1_empty_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (rd_en && !wr_en) count <= count - 1'b1;
      end
   end

   // Storage is not cleared on reset; writes are simply suppressed during it.
   always_ff @(posedge clock) begin
      if (!reset && wr_en) mem[wr_ptr] <= bus.in1_data;
   end

`ifdef FIFO_COUNT_EN
   logic ovf;

   always_ff @(posedge clock) begin
      if (reset)                                  ovf <= 1'b0;
      else if (bus.in1_write && !bus.in1_full_n)  ovf <= 1'b1;
   end

   assign bus.out1_count = count;
   assign bus.out1_ovf   = ovf;
`endif
endmodule

// File: tb/tb_fifo_buffer_stage.sv
// Directed self-checking bench for fifo_buffer_stage (both FIFO_COUNT_EN builds).
module tb_fifo_buffer_stage;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   fifo_buffer_stage_if #(.SIZE(32), .ADDR_W(2)) bus ();

   fifo_buffer_stage #(.SIZE(32), .DEPTH(4), .ADDR_W(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_flags(input string name, input logic full_n, input logic empty_n, input int cnt);
      n_checks++;
      if (bus.in1_full_n !== full_n) begin
         n_fail++; $display("FAIL %s full_n: got %b expected %b", name, bus.in1_full_n, full_n);
      end
      n_checks++;
      if (bus.out1_empty_n !== empty_n) begin
         n_fail++; $display("FAIL %s empty_n: got %b expected %b", name, bus.out1_empty_n, empty_n);
      end
`ifdef FIFO_COUNT_EN
      n_checks++;
      if (bus.out1_count !== 3'(cnt)) begin
         n_fail++; $display("FAIL %s count: got %0d expected %0d", name, bus.out1_count, cnt);
      end
`else
      if (cnt < 0) $display("note: negative count %0d", cnt);
`endif
   endtask

   task automatic chk_data(input string name, input logic [31:0] exp);
      n_checks++;
      if (bus.out1_data !== exp) begin
         n_fail++; $display("FAIL %s data: got %h expected %h", name, bus.out1_data, exp);
      end
   endtask

   task automatic chk_ovf(input string name, input logic exp);
`ifdef FIFO_COUNT_EN
      n_checks++;
      if (bus.out1_ovf !== exp) begin
         n_fail++; $display("FAIL %s ovf: got %b expected %b", name, bus.out1_ovf, exp);
      end
`else
      if (exp === 1'bx) $display("note: %s unknown ovf expectation", name);
`endif
   endtask

   task automatic idle();
      bus.in1_write = 1'b0;
      bus.out1_read = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle(); bus.in1_data = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk_flags("reset", 1'b1, 1'b0, 0);
      chk_ovf("reset", 1'b0);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         bus.in1_data = 32'hA0 + i; bus.in1_write = 1'b1;
         step();
         chk_flags($sformatf("fill%0d", i), (i != 3), 1'b1, i + 1);
         chk_data($sformatf("fill%0d", i), 32'hA0);
      end
      idle();
   endtask

   task automatic test_overflow();
      bus.in1_data = 32'hFF; bus.in1_write = 1'b1;
      step();
      idle();
      chk_flags("ovf", 1'b0, 1'b1, 4);
      chk_ovf("ovf_set", 1'b1);
      bus.out1_read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_data($sformatf("ovf_pop%0d", i), 32'hA0 + i);
         step();
      end
      idle();
      chk_flags("ovf_drained", 1'b1, 1'b0, 0);
      chk_ovf("ovf_sticky", 1'b1);
   endtask

   task automatic test_stream();
      bus.in1_data = 32'h50; bus.in1_write = 1'b1;
      step();
      chk_flags("stream_seed", 1'b1, 1'b1, 1);
      bus.out1_read = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in1_data = i;
         chk_data($sformatf("stream%0d", i), (i == 0) ? 32'h50 : 32'(i - 1));
         step();
         chk_flags($sformatf("stream%0d", i), 1'b1, 1'b1, 1);
      end
      bus.in1_write = 1'b0;
      chk_data("stream_last", 32'd9);
      step();
      idle();
      chk_flags("stream_end", 1'b1, 1'b0, 0);
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 4; i++) begin
         bus.in1_data = 32'hB0 + i; bus.in1_write = 1'b1;
         step();
      end
      chk_flags("frw_full", 1'b0, 1'b1, 4);
      bus.in1_data = 32'hC0; bus.in1_write = 1'b1; bus.out1_read = 1'b1;
      chk_data("frw_head", 32'hB0);
      step();
      bus.in1_write = 1'b0;
      chk_flags("frw_after", 1'b1, 1'b1, 3);
      for (int i = 1; i < 4; i++) begin
         chk_data($sformatf("frw_pop%0d", i), 32'hB0 + i);
         step();
      end
      idle();
      chk_flags("frw_empty", 1'b1, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         bus.in1_data = 32'hE0 + i; bus.in1_write = 1'b1;
         step();
      end
      chk_flags("rmid_pre", 1'b1, 1'b1, 3);
      reset = 1'b1; bus.in1_data = 32'hEE; bus.in1_write = 1'b1; bus.out1_read = 1'b1;
      step();
      reset = 1'b0; idle();
      chk_flags("rmid_post", 1'b1, 1'b0, 0);
      chk_ovf("rmid_post", 1'b0);
      bus.in1_data = 32'hD0; bus.in1_write = 1'b1;
      step();
      idle();
      chk_flags("rmid_wr", 1'b1, 1'b1, 1);
      chk_data("rmid_wr", 32'hD0);
   endtask

   initial begin
      idle();
      test_reset();
      test_fill();
      test_overflow();
      test_stream();
      test_full_rw();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
